// File: rtl/uart_tx_frame.sv
// UART transmitter: serializes one latched word per handshake, LSB first, one bit per CLK,
// framed as start / data / optional parity / stop, with registered TX_OUT and busy.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_tx;
  logic                  r_busy;
  logic                  w_accept;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;

  // Even parity keeps the total count of ones even; odd parity flips that bit.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (DATA_VALID) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_BIT) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
        else                   w_state_nxt = S_DATA;
      end
      S_PARITY: w_state_nxt = S_STOP;
      S_STOP:   w_state_nxt = S_IDLE;
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // Line value is chosen for the state being entered so the flop presents it for that whole cycle.
    w_tx_nxt   = 1'b1;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = r_data[w_cnt_nxt];
      S_PARITY: w_tx_nxt = r_par_bit;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
      if (w_accept) begin
        r_data    <= P_DATA;
        r_par_en  <= PAR_EN;
        r_par_bit <= parity_bit(P_DATA, PAR_TYP);
      end
    end
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: fixed frame vectors, mid-frame reset, continuous-valid spacing,
// and random frames compared against a bit-list model of the UART frame format.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  d;
    logic        en;
    logic        typ;
    logic [10:0] exp;  // bit i = i-th bit on the line
    int          len;
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Frame as a list of line bits: start 0, data LSB first, optional parity, stop 1.
  task automatic model(input logic [7:0] d, input logic en, input logic typ,
                       output logic [10:0] bits, output int len);
    int ones = 0;
    bits = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bits[1 + k] = d[k];
      if (d[k]) ones++;
    end
    len = 10;
    if (en) begin
      bits[9] = ((ones % 2) == 1) ? ~typ : typ;
      len = 11;
    end
    bits[len - 1] = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after stop.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic en, input logic typ,
                           input logic [10:0] exp, input int len);
    P_DATA = d; PAR_EN = en; PAR_TYP = typ; DATA_VALID = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= len; c++) begin
      @(negedge CLK);
      chk($sformatf("%s tx c%0d", tag, c), TX_OUT, exp[c-1]);
      chk($sformatf("%s busy c%0d", tag, c), busy, 1'b1);
      P_DATA = ~d; PAR_EN = ~en; PAR_TYP = ~typ;
      DATA_VALID = (c == 4);
    end
    @(negedge CLK);
    chk($sformatf("%s idle tx", tag), TX_OUT, 1'b1);
    chk($sformatf("%s idle busy", tag), busy, 1'b0);
  endtask

  task automatic continuous(input logic en, input int period);
    int rises[$];
    logic prev_busy;
    logic prev_tx;
    DATA_VALID = 1'b1; PAR_EN = en; PAR_TYP = 1'b0;
    prev_busy = busy; prev_tx = TX_OUT;
    for (int c = 0; c < 4 * period + 2; c++) begin
      @(negedge CLK);
      P_DATA = 8'($urandom);
      if (busy && !prev_busy) begin
        rises.push_back(c);
        chk($sformatf("cont%0d start tx", period), TX_OUT, 1'b0);
        chk($sformatf("cont%0d gap tx", period), prev_tx, 1'b1);
      end
      prev_busy = busy; prev_tx = TX_OUT;
    end
    DATA_VALID = 1'b0;
    checks++;
    if (rises.size() < 3) begin
      errors++;
      $display("FAIL cont%0d starts: got %0d expected >=3", period, rises.size());
    end
    for (int i = 1; i < rises.size(); i++)
      chk($sformatf("cont%0d spacing %0d=%0d", period, i, rises[i] - rises[i-1]),
          (rises[i] - rises[i-1]) == period, 1'b1);
    repeat (period + 2) @(negedge CLK);
  endtask

  initial begin
    vec_t vecs[$];
    logic [10:0] mbits;
    int mlen;

    vecs.push_back('{8'hA5, 1'b0, 1'b0, 11'b01101001010, 10});
    vecs.push_back('{8'h53, 1'b1, 1'b0, 11'b10010100110, 11});
    vecs.push_back('{8'h53, 1'b1, 1'b1, 11'b11010100110, 11});
    vecs.push_back('{8'h01, 1'b1, 1'b1, 11'b10000000010, 11});
    vecs.push_back('{8'hFF, 1'b0, 1'b0, 11'b01111111110, 10});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 11'b10000000000, 11});

    RST = 1'b1; P_DATA = 8'h00; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("reset tx", TX_OUT, 1'b1);
      chk("reset busy", busy, 1'b0);
    end
    RST = 1'b0;
    @(negedge CLK);

    foreach (vecs[i])
      run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].en, vecs[i].typ, vecs[i].exp, vecs[i].len);
    @(negedge CLK);
    chk("no queued frame busy", busy, 1'b0);
    chk("no queued frame tx", TX_OUT, 1'b1);

    // Mid-frame reset abandons the frame for good.
    P_DATA = 8'h00; PAR_EN = 1'b1; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("midrst tx c%0d", c), TX_OUT, 1'b1);
      chk($sformatf("midrst busy c%0d", c), busy, 1'b0);
    end
    RST = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      chk($sformatf("postrst tx c%0d", c), TX_OUT, 1'b1);
      chk($sformatf("postrst busy c%0d", c), busy, 1'b0);
    end

    continuous(1'b1, 12);
    continuous(1'b0, 11);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic en, typ;
      d = 8'($urandom); en = 1'($urandom); typ = 1'($urandom);
      model(d, en, typ, mbits, mlen);
      run_frame($sformatf("rnd%0d d=%02h p=%0b%0b", i, d, en, typ), d, en, typ, mbits, mlen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
